c8237_dev_port: RTL
===================

# c8237_dev_port

Device-side endpoint of the 8237 DMA handshake: the peripheral that raises DREQ, answers DACK-qualified IOR/IOW strobes, and signals or accepts end-of-process. It buffers bytes in an 8-deep FIFO between a simple valid/ready local port and the DMA data bus. It supports both directions: device-to-memory, where the controller issues IOR_n and the port drives DB; and memory-to-device, where the controller issues IOW_n and the port captures DB. It sits beside the c8237_top instance on the system bus, one instance per DMA channel.

## Interface
- DEPTH, 8: FIFO entries. Power of two, ≥4.
- CNTW, 16: transfer-count width.

- CLK  in  1  system clock. Rising edge only.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; arms a transfer. Ignored unless IDLE.
- DIR  in  1  sampled at START. 0 = device→memory (IOR cycles); 1 = memory→device (IOW cycles).
- LEN  in  CNTW  sampled at START; transfers = LEN+1 (8237 count convention).
- DREQ  out  1  DMA request, active-high, registered.
- DACK  in  1  DMA acknowledge, active-high.
- IOR_n  in  1  I/O read strobe, active-low.
- IOW_n  in  1  I/O write strobe, active-low.
- EOP_ni  in  1  external end-of-process, active-low.
- EOP_no  out  1  terminal-count indication, active-low.
- DB_i  in  8  data bus input.
- DB_o  out  8  data bus output.
- DB_oe  out  1  DB_o enable.
- WR_DATA  in  8, WR_VALID  in  1, WR_READY  out  1: local push (DIR=0).
- RD_DATA  out  8, RD_VALID  out  1, RD_READY  in  1: local pop (DIR=1).
- BUSY  out  1  high in ACTIVE/DRAIN.
- DONE  out  1  one-cycle pulse at completion.
- ABORT  out  1  set with DONE when the transfer ended by EOP_ni. Held until next START.
- OVF  out  1  sticky; strobe completed with FIFO full (DIR=1) or empty (DIR=0). Cleared by START.

## Operation
- All bus inputs are synchronous to CLK. A strobe completion is detected as the registered strobe = 0 while the current strobe = 1, qualified by the registered DACK = 1.
- States: IDLE → (START) ACTIVE → DRAIN → DONE → IDLE.
  - ACTIVE → DRAIN when the final transfer completes (remaining = 0 at completion) or when EOP_ni = 0 is sampled while DACK = 1.
  - DRAIN: DIR=1 waits until the FIFO is empty via RD pops; DIR=0 exits immediately, and the FIFO is flushed.
  - DONE lasts one cycle.
- Remaining counter: loaded with LEN at START; decrements on each completion in ACTIVE. A completion with remaining = 0 is the last.
- DIR=0 (device→memory):
  - WR_READY = ACTIVE & not full.
  - DB_o = FIFO head; DB_oe = DACK & ~IOR_n & ACTIVE.
  - Pop on IOR completion.
  - DREQ next = ACTIVE & (level ≥ 2 | level = remaining+1) & ~(completion on last).
- DIR=1 (memory→device):
  - DB_i is registered every cycle that IOW_n = 0; the last registered value is pushed on IOW completion.
  - RD_VALID = not empty (ACTIVE or DRAIN).
  - DREQ next = ACTIVE & free ≥ 2 & ~(completion on last).
  - DB_oe = 0.
- EOP_no = 0 combinationally while DACK = 1, the strobe for DIR is low, ACTIVE, and remaining = 0. Otherwise EOP_no = 1.
- Abort: EOP_ni low with DACK high. A strobe completing in the same cycle is still counted and transferred. ABORT is set and DREQ drops next cycle.
- Over/underflow: the byte is dropped (DIR=1) or DB_o carries a stale value (DIR=0). OVF is set, and the counter still decrements.
- Simultaneous local push/pop and bus completion in the same cycle: both apply; level is unchanged.
- DACK without a strobe, or a strobe without DACK: ignored.

## Timing
- Reset values: DREQ=0, EOP_no=1, DB_oe=0, DB_o=0, WR_READY=0, RD_VALID=0, BUSY=0, DONE=0, ABORT=0, OVF=0. State = IDLE; FIFO empty; counter 0.
- RESET mid-transfer aborts silently: no DONE is produced.
- START → BUSY=1 next cycle; earliest DREQ is 2 cycles after START.
- Strobe completion (rising edge) → push/pop visible in the level one cycle later. DREQ reflects the new level one cycle after that.
- DONE is exactly one cycle. BUSY falls in the same cycle DONE rises.

## Test plan
- DIR=0, LEN=3: push A0..A3 locally. The bench acts as the 8237 issuing 4 IOR cycles with DACK. DB_o must read A0,A1,A2,A3. EOP_no must be low only during the 4th IOR. DONE=1, ABORT=0, and DREQ is low afterwards.
- DIR=1, LEN=7: 8 IOW cycles with 10..17 while RD_READY=0. DREQ must drop when free < 2. After RD pops, DREQ must reassert. RD_DATA must be 10..17 in order, and DONE fires after the FIFO drains.
- DIR=1, LEN=15: EOP_ni pulsed low with DACK during the 5th IOW. 5 bytes must be delivered, followed by ABORT=1 and DONE.
- DIR=1: force IOW completions with FIFO full (RD_READY=0, DREQ ignored). OVF must be 1, and the 9th byte is absent from RD_DATA.
- RESET asserted mid-transfer: all outputs must return to reset values next cycle. A subsequent START with LEN=0 must complete one transfer normally.
- START while BUSY: ignored; LEN and DIR are unchanged.

Source files
------------

// File: rtl/c8237_dev_port.sv
// c8237_dev_port: peripheral side of the 8237 DMA handshake for one channel.
// Raises DREQ, answers DACK-qualified IOR/IOW strobes and signals or accepts
// end-of-process. An internal FIFO sits between the local valid/ready port
// and the DMA data bus. DIR=0 moves device data to memory (IOR cycles);
// DIR=1 moves memory data to the device (IOW cycles).
module c8237_dev_port #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            DIR,
  input  logic [CNTW-1:0] LEN,
  output logic            DREQ,
  input  logic            DACK,
  input  logic            IOR_n,
  input  logic            IOW_n,
  input  logic            EOP_ni,
  output logic            EOP_no,
  input  logic [7:0]      DB_i,
  output logic [7:0]      DB_o,
  output logic            DB_oe,
  input  logic [7:0]      WR_DATA,
  input  logic            WR_VALID,
  output logic            WR_READY,
  output logic [7:0]      RD_DATA,
  output logic            RD_VALID,
  input  logic            RD_READY,
  output logic            BUSY,
  output logic            DONE,
  output logic            ABORT,
  output logic            OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]   TWO_L   = {{(LW-2){1'b0}}, 2'b10};
  localparam logic [LW-1:0]   LVL_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic            dir_r;
  logic [CNTW-1:0] remaining_r;
  logic            ior_r, iow_r, dack_r;
  logic [7:0]      db_cap_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            dreq_r, busy_r, done_r, abort_r, ovf_r;

  logic            active_s, drain_s, start_ok_s;
  logic            strb_now_s, strb_reg_s, cmp_s, last_s, abort_s;
  logic            empty_s, full_s, wr_ready_s, rd_valid_s;
  logic            push_s, pop_s, ovf_hit_s, flush_s;
  logic [7:0]      push_data_s;
  logic            dreq_cond_s, dreq_s;
  logic [CNTW:0]   level_ext_s, rem_p1_s;

  assign active_s   = (state_r == ST_ACTIVE);
  assign drain_s    = (state_r == ST_DRAIN);
  assign start_ok_s = (state_r == ST_IDLE) && START;
  assign empty_s    = (level_r == {LW{1'b0}});
  assign full_s     = (level_r == DEPTH_L);

  // Bus strobe selection and completion/abort detection for the latched direction.
  always_comb begin
    strb_now_s = IOR_n;
    strb_reg_s = ior_r;
    if (dir_r) begin
      strb_now_s = IOW_n;
      strb_reg_s = iow_r;
    end else begin
      strb_now_s = IOR_n;
      strb_reg_s = ior_r;
    end
    // A completion is the rising edge of the strobe while DACK was held.
    cmp_s   = active_s && dack_r && !strb_reg_s && strb_now_s;
    last_s  = cmp_s && (remaining_r == CNT_ZERO);
    abort_s = active_s && DACK && !EOP_ni;
  end

  // FIFO push/pop sources: local port on one side, bus completions on the other.
  always_comb begin
    wr_ready_s  = active_s && !dir_r && !full_s;
    rd_valid_s  = dir_r && !empty_s && (active_s || drain_s);
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = WR_DATA;
    ovf_hit_s   = 1'b0;
    if (dir_r) begin
      push_s      = cmp_s && !full_s;
      push_data_s = db_cap_r;
      pop_s       = rd_valid_s && RD_READY;
      ovf_hit_s   = cmp_s && full_s;
    end else begin
      push_s      = WR_VALID && wr_ready_s;
      push_data_s = WR_DATA;
      pop_s       = cmp_s && !empty_s;
      ovf_hit_s   = cmp_s && empty_s;
    end
    // Device-to-memory leftovers are discarded on the way out; every START begins empty.
    flush_s = (drain_s && !dir_r) || start_ok_s;
  end

  // Next DREQ: request only while enough data/space exists, and never past the last transfer.
  always_comb begin
    level_ext_s = {{(CNTW + 1 - LW){1'b0}}, level_r};
    rem_p1_s    = {1'b0, remaining_r} + {{CNTW{1'b0}}, 1'b1};
    if (dir_r) begin
      dreq_cond_s = ((DEPTH_L - level_r) >= TWO_L);
    end else begin
      dreq_cond_s = (level_r >= TWO_L) || (level_ext_s == rem_p1_s);
    end
    dreq_s = active_s && dreq_cond_s && !last_s && !abort_s;
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) state_s = ST_ACTIVE;
        else       state_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (last_s || abort_s) state_s = ST_DRAIN;
        else                   state_s = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (!dir_r || empty_s) state_s = ST_DONE;
        else                   state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Sequencer state, latched transfer setup and remaining-transfer counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      dir_r       <= 1'b0;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        dir_r       <= DIR;
        remaining_r <= LEN;
      end else if (cmp_s && (remaining_r != CNT_ZERO)) begin
        remaining_r <= remaining_r - CNT_ONE;
      end
    end
  end

  // Bus input sampling for edge detection and IOW data capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ior_r    <= 1'b1;
      iow_r    <= 1'b1;
      dack_r   <= 1'b0;
      db_cap_r <= 8'h00;
    end else begin
      ior_r  <= IOR_n;
      iow_r  <= IOW_n;
      dack_r <= DACK;
      if (!IOW_n) db_cap_r <= DB_i;
    end
  end

  // FIFO storage, pointers and fill level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      dreq_r <= dreq_s;
      busy_r <= (state_s == ST_ACTIVE) || (state_s == ST_DRAIN);
      done_r <= (state_s == ST_DONE);
      if (start_ok_s) begin
        abort_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        if (abort_s)   abort_r <= 1'b1;
        if (ovf_hit_s) ovf_r   <= 1'b1;
      end
    end
  end

  assign DREQ     = dreq_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign ABORT    = abort_r;
  assign OVF      = ovf_r;
  assign WR_READY = wr_ready_s;
  assign RD_VALID = rd_valid_s;
  assign DB_o     = mem_r[rd_ptr_r];
  assign RD_DATA  = mem_r[rd_ptr_r];
  assign DB_oe    = DACK && !IOR_n && active_s && !dir_r;
  assign EOP_no   = !(DACK && !strb_now_s && active_s && (remaining_r == CNT_ZERO));

endmodule
